// File: rtl/vga_fb_reader.sv
// -----------------------------------------------------------------------------
// vga_fb_reader
//
// Wishbone classic read master that streams a framebuffer into the write side
// of the VGA pixel FIFO. Pixel words are fetched in raster order, starting at
// BASE_ADR and wrapping back to it after HDISP*VDISP words. Each fetched word
// contributes its low 24 bits (RGB) to the FIFO.
//
// A frame_resync pulse restarts the fetch at BASE_ADR. If a bus cycle is in
// flight when it arrives, that cycle is allowed to finish normally on the bus,
// but its data is dropped and the pixel counter is not advanced.
//
// Ports
//   wshb_clk          wishbone clock, also the FIFO write clock
//   wshb_rst_n        asynchronous reset, active low
//   enable            1 = fetching allowed; 0 = finish the current cycle, idle
//   frame_resync      single-cycle pulse: restart the frame at BASE_ADR
//   wshb_adr          byte address of the word being requested
//   wshb_cyc/stb      bus cycle / strobe (both high only in REQ)
//   wshb_we/sel/cti/bte  constant: read, all bytes, classic, linear
//   wshb_dat_sm       read data, valid with wshb_ack
//   wshb_ack          slave acknowledge
//   fifo_wdata        RGB pixel pushed to the FIFO
//   fifo_write        one-cycle FIFO write strobe, one cycle after the ack
//   fifo_walmost_full FIFO can take at most one more word
//   pix_index         index of the next pixel to be requested
// -----------------------------------------------------------------------------
module vga_fb_reader #(
  parameter int unsigned HDISP    = 800,
  parameter int unsigned VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  localparam int unsigned NPIX    = HDISP * VDISP,
  localparam int unsigned PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic             wshb_clk,
  input  logic             wshb_rst_n,
  input  logic             enable,
  input  logic             frame_resync,
  output logic [31:0]      wshb_adr,
  output logic             wshb_cyc,
  output logic             wshb_stb,
  output logic             wshb_we,
  output logic [3:0]       wshb_sel,
  output logic [2:0]       wshb_cti,
  output logic [1:0]       wshb_bte,
  input  logic [31:0]      wshb_dat_sm,
  input  logic             wshb_ack,
  output logic [23:0]      fifo_wdata,
  output logic             fifo_write,
  input  logic             fifo_walmost_full,
  output logic [PIX_W-1:0] pix_index
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);

  state_t state_reg, state_next;

  logic [31:0]      adr_reg,        adr_next;
  logic [PIX_W-1:0] pix_reg,        pix_next;
  logic             discard_reg,    discard_next;
  logic             fifo_write_reg, fifo_write_next;
  logic [23:0]      fifo_wdata_reg, fifo_wdata_next;

  logic go_ok;     // a new request may be issued
  logic in_req;    // a bus cycle is currently on the bus
  logic ack_keep;  // ack whose data goes to the FIFO
  logic ack_drop;  // ack whose data is thrown away because of a resync
  logic last_pix;

  // The upper byte of each pixel word carries no colour information.
  logic unused_dat_hi;
  assign unused_dat_hi = ^wshb_dat_sm[31:24];

  assign go_ok    = enable && !fifo_walmost_full;
  assign in_req   = (state_reg == ST_REQ);
  // A resync arriving together with the ack discards that word, exactly as
  // if the discard flag had already been set.
  assign ack_keep = in_req && wshb_ack && !discard_reg && !frame_resync;
  assign ack_drop = in_req && wshb_ack && (discard_reg || frame_resync);
  assign last_pix = (pix_reg == LAST_PIX);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and bus control. cyc/stb decode straight from the state
  // register so an asynchronous reset removes them immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    wshb_cyc   = 1'b0;
    wshb_stb   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (go_ok) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        wshb_cyc = 1'b1;
        wshb_stb = 1'b1;
        // The strobe is never withdrawn before the ack: almost-full or a
        // disable arriving mid-cycle only takes effect once the ack is in.
        if (wshb_ack) begin
          if (go_ok) begin
            state_next = ST_REQ;
          end else if (!enable) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (go_ok) begin
          state_next = ST_REQ;
        end else if (!enable) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address / pixel counter / discard flag / FIFO write path
  // ---------------------------------------------------------------------------
  always_comb begin
    adr_next        = adr_reg;
    pix_next        = pix_reg;
    discard_next    = discard_reg;
    fifo_write_next = 1'b0;
    fifo_wdata_next = fifo_wdata_reg;

    if (ack_keep) begin
      fifo_write_next = 1'b1;
      fifo_wdata_next = wshb_dat_sm[23:0];
      if (last_pix) begin
        adr_next = BASE_ADR;
        pix_next = '0;
      end else begin
        adr_next = adr_reg + 32'd4;
        pix_next = pix_reg + PIX_W'(1);
      end
    end else if (ack_drop || (!in_req && frame_resync)) begin
      // Restart only when no cycle is left on the bus, so the address seen
      // by the slave stays stable until its ack.
      adr_next = BASE_ADR;
      pix_next = '0;
    end

    if (ack_drop) begin
      discard_next = 1'b0;
    end else if (in_req && frame_resync) begin
      discard_next = 1'b1;
    end
  end

  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) begin
      adr_reg        <= BASE_ADR;
      pix_reg        <= '0;
      discard_reg    <= 1'b0;
      fifo_write_reg <= 1'b0;
      fifo_wdata_reg <= 24'd0;
    end else begin
      adr_reg        <= adr_next;
      pix_reg        <= pix_next;
      discard_reg    <= discard_next;
      fifo_write_reg <= fifo_write_next;
      fifo_wdata_reg <= fifo_wdata_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wshb_adr   = adr_reg;
  assign wshb_we    = 1'b0;
  assign wshb_sel   = 4'b1111;
  assign wshb_cti   = 3'b000;
  assign wshb_bte   = 2'b00;
  assign fifo_wdata = fifo_wdata_reg;
  assign fifo_write = fifo_write_reg;
  assign pix_index  = pix_reg;

endmodule

// File: tb/tb_vga_fb_reader.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_reader
//
// Bench for vga_fb_reader with a 4x2 frame at base 0x100. A wishbone slave
// with a configurable number of wait states returns random data; a reference
// model tracks which pixel should be requested next and which words must
// reach the FIFO, one cycle after their ack.
// Inputs are driven 1 ns after the falling edge; the slave/model samples
// 2 ns after the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_fb_reader;

  localparam int unsigned HDISP = 4;
  localparam int unsigned VDISP = 2;
  localparam int unsigned NPIX  = HDISP * VDISP;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        wshb_clk          = 1'b0;
  logic        wshb_rst_n        = 1'b0;
  logic        enable            = 1'b0;
  logic        frame_resync      = 1'b0;
  logic        fifo_walmost_full = 1'b0;
  logic        wshb_ack          = 1'b0;
  logic [31:0] wshb_dat_sm       = 32'd0;
  logic [31:0] wshb_adr;
  logic        wshb_cyc, wshb_stb, wshb_we;
  logic [3:0]  wshb_sel;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic [23:0] fifo_wdata;
  logic        fifo_write;
  logic [2:0]  pix_index;

  int n_checks = 0;
  int n_pass   = 0;

  vga_fb_reader #(
    .HDISP    (HDISP),
    .VDISP    (VDISP),
    .BASE_ADR (BASE)
  ) dut (
    .wshb_clk          (wshb_clk),
    .wshb_rst_n        (wshb_rst_n),
    .enable            (enable),
    .frame_resync      (frame_resync),
    .wshb_adr          (wshb_adr),
    .wshb_cyc          (wshb_cyc),
    .wshb_stb          (wshb_stb),
    .wshb_we           (wshb_we),
    .wshb_sel          (wshb_sel),
    .wshb_cti          (wshb_cti),
    .wshb_bte          (wshb_bte),
    .wshb_dat_sm       (wshb_dat_sm),
    .wshb_ack          (wshb_ack),
    .fifo_wdata        (fifo_wdata),
    .fifo_write        (fifo_write),
    .fifo_walmost_full (fifo_walmost_full),
    .pix_index         (pix_index)
  );

  always #5 wshb_clk = ~wshb_clk;

  // ---------------------------------------------------------------------------
  // Slave + reference model
  // ---------------------------------------------------------------------------
  int          min_wait = 0;
  int          max_wait = 0;
  int          exp_pix  = 0;      // pixel the DUT should be requesting
  bit          disc     = 1'b0;   // resync seen while a cycle was pending
  bit          in_req   = 1'b0;
  int          wait_left = 0;
  logic [31:0] held_adr = 32'd0;
  logic [31:0] mon_dat  = 32'd0;
  logic [23:0] exp_q[$];          // words due at the FIFO
  logic [31:0] acc_q[$];          // addresses of accepted (non-dropped) acks
  int          acc_count  = 0;
  int          drop_count = 0;
  int          wr_count   = 0;
  int          mon_err    = 0;
  int          err_code   = 0;
  logic [31:0] err_got    = 32'd0;
  logic [31:0] err_want   = 32'd0;

  task automatic mon_note(input int code, input logic [31:0] got, input logic [31:0] want);
    mon_err++;
    if (mon_err == 1) begin
      err_code = code;
      err_got  = got;
      err_want = want;
    end
  endtask

  always @(negedge wshb_clk) begin
    logic [31:0] exp_adr;
    logic [23:0] w;
    bit          ack_now;
    #2;
    ack_now = 1'b0;
    if (!wshb_rst_n) begin
      exp_q.delete();
      exp_pix = 0;
      disc    = 1'b0;
      in_req  = 1'b0;
    end else begin
      // FIFO side: a word accepted last cycle must show up now, exactly once.
      if (fifo_write === 1'b1) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          mon_note(1, {8'd0, fifo_wdata}, 32'd0);
        end else begin
          w = exp_q.pop_front();
          if (fifo_wdata !== w) mon_note(2, {8'd0, fifo_wdata}, {8'd0, w});
        end
      end
      if (exp_q.size() != 0) begin
        mon_note(3, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
      if (wshb_cyc !== wshb_stb) mon_note(4, {31'd0, wshb_cyc}, {31'd0, wshb_stb});
      // Bus side
      if (wshb_stb === 1'b1) begin
        exp_adr = BASE + 32'(4 * exp_pix);
        if (wshb_adr !== exp_adr) mon_note(5, wshb_adr, exp_adr);
        if (pix_index !== 3'(exp_pix)) mon_note(6, {29'd0, pix_index}, 32'(exp_pix));
        if (in_req && (wshb_adr !== held_adr)) mon_note(7, wshb_adr, held_adr);
        if (!in_req) begin
          in_req    = 1'b1;
          held_adr  = wshb_adr;
          wait_left = int'($urandom_range(max_wait, min_wait));
        end
        if (wait_left == 0) begin
          ack_now = 1'b1;
          in_req  = 1'b0;
          mon_dat = $urandom;
          if (frame_resync || disc) begin
            disc    = 1'b0;
            exp_pix = 0;
            drop_count++;
          end else begin
            exp_q.push_back(mon_dat[23:0]);
            acc_q.push_back(wshb_adr);
            acc_count++;
            exp_pix = (exp_pix + 1) % NPIX;
          end
        end else begin
          wait_left--;
          if (frame_resync) disc = 1'b1;
        end
      end else begin
        if (in_req) mon_note(8, 32'd0, 32'd1);
        in_req = 1'b0;
        if (frame_resync) exp_pix = 0;
      end
    end
    wshb_ack    = ack_now;
    wshb_dat_sm = ack_now ? mon_dat : 32'hDEAD_BEEF;
  end

  // ---------------------------------------------------------------------------
  // Helpers (stimulus timing only)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge wshb_clk);
    #1;
  endtask

  task automatic wait_stb_adr(input logic [31:0] a, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (wshb_stb === 1'b1 && wshb_adr === a) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_acc(input int target, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (acc_count >= target) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    wshb_rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (wshb_cyc !== 1'b0) $display("FAIL reset_cyc got=%b want=0", wshb_cyc); else n_pass++;
    n_checks++; if (wshb_stb !== 1'b0) $display("FAIL reset_stb got=%b want=0", wshb_stb); else n_pass++;
    n_checks++; if (wshb_adr !== BASE) $display("FAIL reset_adr got=%h want=%h", wshb_adr, BASE); else n_pass++;
    n_checks++; if (pix_index !== 3'd0) $display("FAIL reset_pix got=%0d want=0", pix_index); else n_pass++;
    n_checks++; if (fifo_write !== 1'b0) $display("FAIL reset_fifo_write got=%b want=0", fifo_write); else n_pass++;
    n_checks++; if (fifo_wdata !== 24'd0) $display("FAIL reset_fifo_wdata got=%h want=0", fifo_wdata); else n_pass++;
    n_checks++;
    if ({wshb_we, wshb_sel, wshb_cti, wshb_bte} !== 10'b0_1111_000_00)
      $display("FAIL bus_constants got=%b want=0111100000", {wshb_we, wshb_sel, wshb_cti, wshb_bte});
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    int  a0;
    int  w0;
    int  hi;
    bit  found;
    bit  seq_ok;
    min_wait = 0;
    max_wait = 0;
    enable   = 1'b1;
    wshb_rst_n = 1'b1;
    a0 = acc_count;
    wait_acc(a0 + 10, 200, found);
    n_checks++; if (!found) $display("FAIL stream_timeout got=%0d want=%0d accepts", acc_count - a0, 10); else n_pass++;
    seq_ok = 1'b1;
    for (int i = 0; i < 10 && found; i++) begin
      if (acc_q[a0 + i] !== BASE + 32'(4 * (i % NPIX))) begin
        $display("FAIL stream_adr[%0d] got=%h want=%h", i, acc_q[a0 + i], BASE + 32'(4 * (i % NPIX)));
        seq_ok = 1'b0;
      end
    end
    n_checks++; if (!seq_ok || !found) $display("FAIL stream_sequence got=bad want=100..11C,100,104"); else n_pass++;
    hi = 0;
    w0 = wr_count;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (wshb_stb === 1'b1) hi++;
    end
    n_checks++; if (hi != 16) $display("FAIL back_to_back got=%0d want=16 stb cycles", hi); else n_pass++;
    n_checks++; if (wr_count - w0 != 16) $display("FAIL stream_writes got=%0d want=16", wr_count - w0); else n_pass++;
    n_checks++; if (mon_err != 0) $display("FAIL stream_model code=%0d got=%h want=%h errors=%0d", err_code, err_got, err_want, mon_err); else n_pass++;
    $display("test_stream done accepts=%0d", acc_count - a0);
  endtask

  task automatic test_random_waits();
    int a0;
    bit found;
    min_wait = 0;
    max_wait = 3;
    a0 = acc_count;
    wait_acc(a0 + 30, 400, found);
    n_checks++; if (!found) $display("FAIL waits_timeout got=%0d want=30 accepts", acc_count - a0); else n_pass++;
    n_checks++; if (mon_err != 0) $display("FAIL waits_model code=%0d got=%h want=%h errors=%0d", err_code, err_got, err_want, mon_err); else n_pass++;
    $display("test_random_waits done accepts=%0d", acc_count - a0);
  endtask

  task automatic test_almost_full();
    int a0;
    int hi;
    bit found;
    min_wait = 0;
    max_wait = 0;
    wait_stb_adr(BASE + 32'h8, 50, found);
    n_checks++; if (!found) $display("FAIL af_find got=none want=adr 108"); else n_pass++;
    a0 = acc_count;
    fifo_walmost_full = 1'b1;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wshb_stb !== 1'b0) hi++;
    end
    n_checks++; if (acc_count != a0 + 1 || acc_q[a0] !== BASE + 32'h8)
      $display("FAIL af_inflight got=%0d accepts want=1 at 108", acc_count - a0);
    else n_pass++;
    n_checks++; if (hi != 0) $display("FAIL af_hold got=%0d want=0 stb cycles", hi); else n_pass++;
    fifo_walmost_full = 1'b0;
    wait_acc(a0 + 2, 20, found);
    n_checks++; if (!found || acc_q[a0 + 1] !== BASE + 32'hC)
      $display("FAIL af_resume got=%h want=%h", found ? acc_q[a0 + 1] : 32'hFFFF_FFFF, BASE + 32'hC);
    else n_pass++;
    n_checks++; if (mon_err != 0) $display("FAIL af_model code=%0d got=%h want=%h errors=%0d", err_code, err_got, err_want, mon_err); else n_pass++;
    $display("test_almost_full done");
  endtask

  task automatic test_resync_in_flight();
    int a0;
    int d0;
    bit found;
    min_wait = 2;
    max_wait = 2;
    wait_stb_adr(BASE + 32'h10, 60, found);
    n_checks++; if (!found) $display("FAIL rs_find got=none want=adr 110"); else n_pass++;
    a0 = acc_count;
    d0 = drop_count;
    frame_resync = 1'b1;
    tick();
    frame_resync = 1'b0;
    wait_acc(a0 + 1, 30, found);
    n_checks++; if (drop_count != d0 + 1) $display("FAIL rs_drop got=%0d want=1 dropped", drop_count - d0); else n_pass++;
    n_checks++; if (!found || acc_q[a0] !== BASE)
      $display("FAIL rs_restart got=%h want=%h", found ? acc_q[a0] : 32'hFFFF_FFFF, BASE);
    else n_pass++;
    tick();
    n_checks++; if (mon_err != 0) $display("FAIL rs_model code=%0d got=%h want=%h errors=%0d", err_code, err_got, err_want, mon_err); else n_pass++;
    $display("test_resync_in_flight done");
  endtask

  task automatic test_resync_on_ack();
    int a0;
    int d0;
    bit found;
    min_wait = 0;
    max_wait = 0;
    wait_stb_adr(BASE + 32'h1C, 60, found);
    n_checks++; if (!found) $display("FAIL rsa_find got=none want=adr 11C"); else n_pass++;
    a0 = acc_count;
    d0 = drop_count;
    frame_resync = 1'b1;
    tick();
    frame_resync = 1'b0;
    wait_acc(a0 + 1, 20, found);
    n_checks++; if (drop_count != d0 + 1) $display("FAIL rsa_drop got=%0d want=1 dropped", drop_count - d0); else n_pass++;
    n_checks++; if (!found || acc_q[a0] !== BASE)
      $display("FAIL rsa_restart got=%h want=%h", found ? acc_q[a0] : 32'hFFFF_FFFF, BASE);
    else n_pass++;
    tick();
    n_checks++; if (mon_err != 0) $display("FAIL rsa_model code=%0d got=%h want=%h errors=%0d", err_code, err_got, err_want, mon_err); else n_pass++;
    $display("test_resync_on_ack done");
  endtask

  task automatic test_enable_low();
    int a0;
    int hi;
    bit found;
    min_wait = 1;
    max_wait = 1;
    wait_stb_adr(BASE + 32'h4, 60, found);
    n_checks++; if (!found) $display("FAIL en_find got=none want=adr 104"); else n_pass++;
    a0 = acc_count;
    enable = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (acc_count != a0 + 1 || acc_q[a0] !== BASE + 32'h4)
      $display("FAIL en_complete got=%0d accepts want=1 at 104", acc_count - a0);
    else n_pass++;
    n_checks++; if (pix_index !== 3'd2) $display("FAIL en_pix got=%0d want=2", pix_index); else n_pass++;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (wshb_cyc !== 1'b0) hi++;
      tick();
    end
    n_checks++; if (hi != 0) $display("FAIL en_idle got=%0d want=0 cyc cycles", hi); else n_pass++;
    enable = 1'b1;
    wait_acc(a0 + 2, 20, found);
    n_checks++; if (!found || acc_q[a0 + 1] !== BASE + 32'h8)
      $display("FAIL en_resume got=%h want=%h", found ? acc_q[a0 + 1] : 32'hFFFF_FFFF, BASE + 32'h8);
    else n_pass++;
    $display("test_enable_low done");
  endtask

  task automatic test_reset_mid_cycle();
    int a0;
    bit found;
    min_wait = 2;
    max_wait = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (wshb_stb === 1'b1 && wshb_adr !== BASE) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL rst_find got=none want=stb away from base"); else n_pass++;
    #2;
    wshb_rst_n = 1'b0;
    #1;
    n_checks++; if ({wshb_cyc, wshb_stb} !== 2'b00) $display("FAIL rst_async_bus got=%b want=00", {wshb_cyc, wshb_stb}); else n_pass++;
    n_checks++; if (wshb_adr !== BASE) $display("FAIL rst_async_adr got=%h want=%h", wshb_adr, BASE); else n_pass++;
    n_checks++; if (pix_index !== 3'd0) $display("FAIL rst_async_pix got=%0d want=0", pix_index); else n_pass++;
    tick();
    n_checks++; if (fifo_write !== 1'b0) $display("FAIL rst_no_write got=%b want=0", fifo_write); else n_pass++;
    tick();
    a0 = acc_count;
    wshb_rst_n = 1'b1;
    wait_acc(a0 + 1, 20, found);
    n_checks++; if (!found || acc_q[a0] !== BASE)
      $display("FAIL rst_restart got=%h want=%h", found ? acc_q[a0] : 32'hFFFF_FFFF, BASE);
    else n_pass++;
    $display("test_reset_mid_cycle done");
  endtask

  task automatic test_random_mix();
    int a0;
    bit found;
    min_wait = 0;
    max_wait = 3;
    a0 = acc_count;
    for (int i = 0; i < 400; i++) begin
      tick();
      enable            = ($urandom_range(0, 9) != 0);
      fifo_walmost_full = ($urandom_range(0, 4) == 0);
      frame_resync      = frame_resync ? 1'b0 : ($urandom_range(0, 99) < 4);
    end
    tick();
    frame_resync      = 1'b0;
    enable            = 1'b1;
    fifo_walmost_full = 1'b0;
    wait_acc(acc_count + 5, 60, found);
    n_checks++; if (!found || acc_count - a0 < 50) $display("FAIL mix_progress got=%0d want>=50 accepts", acc_count - a0); else n_pass++;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (wshb_cyc !== 1'b0) $display("FAIL mix_drain_cyc got=%b want=0", wshb_cyc); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL mix_pending got=%0d want=0 words", exp_q.size()); else n_pass++;
    n_checks++; if (mon_err != 0) $display("FAIL mix_model code=%0d got=%h want=%h errors=%0d", err_code, err_got, err_want, mon_err); else n_pass++;
    $display("test_random_mix done accepts=%0d drops=%0d", acc_count - a0, drop_count);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_random_waits();
    test_almost_full();
    test_resync_in_flight();
    test_resync_on_ack();
    test_enable_low();
    test_reset_mid_cycle();
    test_random_mix();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
